// File: rtl/instr_enc_pkg.sv
// Shared MIPS encoding constants, op_sel enumeration and the combinational encoder.
// INSTR_ENC_JALR_EN: when defined, op_sel 11 (jalr) is a legal request.
package instr_enc_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_ORI  = 4'd2,
      OP_LW   = 4'd3,
      OP_SW   = 4'd4,
      OP_BEQ  = 4'd5,
      OP_LUI  = 4'd6,
      OP_SLL  = 4'd7,
      OP_J    = 4'd8,
      OP_JAL  = 4'd9,
      OP_JR   = 4'd10,
      OP_JALR = 4'd11
   } op_sel_e;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_LUI   = 6'h0F;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_JAL   = 6'h03;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;

   localparam logic [31:0] ADDR_BASE  = 32'h0000_3000;
   localparam int          FIFO_W     = 64;
   localparam int          FIFO_D     = 4;
   localparam int          FIFO_CNT_W = $clog2(FIFO_D + 1);

   function automatic logic op_legal(input logic [3:0] op);
`ifdef INSTR_ENC_JALR_EN
      return op <= 4'd11;
`else
      return op <= 4'd10;
`endif
   endfunction

   // Fields an op does not use are forced to zero here, not left to the caller.
   function automatic logic [31:0] encode(input op_sel_e op,
                                          input logic [4:0] rs,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd,
                                          input logic [4:0] shamt,
                                          input logic [15:0] imm16,
                                          input logic [25:0] imm26);
      logic [31:0] w;
      w = '0;
      case (op)
         OP_ADD:  w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
         OP_SUB:  w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
         OP_ORI:  w = {OPC_ORI, rs, rt, imm16};
         OP_LW:   w = {OPC_LW, rs, rt, imm16};
         OP_SW:   w = {OPC_SW, rs, rt, imm16};
         OP_BEQ:  w = {OPC_BEQ, rs, rt, imm16};
         OP_LUI:  w = {OPC_LUI, 5'd0, rt, imm16};
         OP_SLL:  w = {OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
         OP_J:    w = {OPC_J, imm26};
         OP_JAL:  w = {OPC_JAL, imm26};
         OP_JR:   w = {OPC_RTYPE, rs, 15'd0, FN_JR};
         OP_JALR: w = {OPC_RTYPE, rs, 5'd0, rd, 5'd0, FN_JALR};
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Synchronous FIFO with synchronous flush; full blocks push even when a pop is in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module enc_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic                           push_i,
   input  logic                           pop_i,
   input  logic [WIDTH-1:0]               data_i,
   output logic [WIDTH-1:0]               data_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o,
   output logic                           full_o,
   output logic                           empty_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PTR_W'(1);
         if (do_pop)  rd_d = rd_q + PTR_W'(1);
         cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: the consumer only looks at it while non-empty.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/instr_enc.sv
// MIPS instruction encoder: legal requests are encoded and queued; the head word is presented with its address.
// INSTR_ENC_JALR_EN: when defined, op_sel 11 encodes jalr instead of being rejected as illegal.
module instr_enc
   import instr_enc_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        flush_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [3:0]  op_sel_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  shamt_i,
   input  logic [15:0] imm16_i,
   input  logic [25:0] imm26_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_instr_o,
   output logic [31:0] out_addr_o,
   output logic        err_o,
   output logic [7:0]  err_cnt_o
);
   logic                  accept, legal, push, pop, illegal_acc;
   logic [31:0]           enc_word, slot_addr;
   logic [FIFO_W-1:0]     head;
   logic [FIFO_CNT_W-1:0] count;
   logic                  full, empty;
   logic [31:0]           addr_q, addr_d;
   logic                  err_q, err_d;
   logic [7:0]            err_cnt_q, err_cnt_d;

   assign legal       = op_legal(op_sel_i);
   assign enc_word    = encode(op_sel_e'(op_sel_i), rs_i, rt_i, rd_i, shamt_i, imm16_i, imm26_i);
   assign accept      = in_valid_i & in_ready_o;
   assign push        = accept & legal & ~flush_i;
   assign illegal_acc = accept & ~legal & ~flush_i;
   assign pop         = out_valid_o & out_ready_i;

   // Each entry is tagged with the address it will be emitted at: head address plus its queue position.
   assign slot_addr = addr_q + (32'(count) << 2);

   enc_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_D)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (reset_i),
      .flush_i (flush_i),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  ({slot_addr, enc_word}),
      .data_o  (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   assign in_ready_o  = ~full;
   assign out_valid_o = ~empty;
   assign out_instr_o = empty ? 32'd0 : head[31:0];
   assign out_addr_o  = empty ? addr_q : head[63:32];
   assign err_o       = err_q;
   assign err_cnt_o   = err_cnt_q;

   always_comb begin
      addr_d    = addr_q;
      err_d     = illegal_acc;
      err_cnt_d = err_cnt_q;
      if (flush_i)  addr_d = ADDR_BASE;
      else if (pop) addr_d = addr_q + 32'd4;
      if (illegal_acc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         addr_q    <= ADDR_BASE;
         err_q     <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         addr_q    <= addr_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

endmodule

// File: doc/instr_enc.md
INSTR_ENC -- requirements
Module: instr_enc

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state.
REQ-003 flush  input  1  synchronous clear of queue and address counter.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  request accepted when in_valid & in_ready.
REQ-006 op_sel  input  4  0 add, 1 sub, 2 ori, 3 lw, 4 sw, 5 beq, 6 lui, 7 sll, 8 j, 9 jal, 10 jr, 11 jalr; 12-15 illegal.
REQ-007 rs, rt, rd, shamt  input  5 each  register and shift fields.
REQ-008 imm16  input  16  immediate or offset field.
REQ-009 imm26  input  26  jump index field.
REQ-010 out_valid  output  1  encoded word available.
REQ-011 out_ready  input  1  consumer accepts when out_valid & out_ready.
REQ-012 out_instr  output  32  encoded MIPS word.
REQ-013 out_addr  output  32  instruction-memory address for out_instr.
REQ-014 err  output  1  one-cycle pulse on an illegal request.
REQ-015 err_cnt  output  8  saturating count of illegal requests.

Function
REQ-016 Opcode and func encodings:
- add: func 0x20
- sub: func 0x22
- ori: opcode 0x0D
- lw: opcode 0x23
- sw: opcode 0x2B
- beq: opcode 0x04
- lui: opcode 0x0F
- sll: func 0x00
- j: opcode 0x02
- jal: opcode 0x03
- jr: func 0x08
- jalr: func 0x09
- All R-type ops use opcode 0x00.
REQ-017 Field placement: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], func [5:0], imm16 [15:0], imm26 [25:0].
REQ-018 Fields unused by an op are forced to 0:
- shamt is 0 except for sll.
- rs is 0 for lui and sll.
- rt, rd and shamt are 0 for jr.
- rt and shamt are 0 for jalr.
REQ-019 Legal requests are encoded combinationally and pushed into a 4-entry FIFO on the accepting edge.
REQ-020 An accepted request appears at the output no earlier than the next cycle; there is no same-cycle bypass.
REQ-021 in_ready = 1 when the FIFO holds fewer than 4 entries, independent of out_ready.
REQ-022 When full, in_ready = 0; a simultaneous pop does not free the slot until the next cycle.
REQ-023 Simultaneous push and pop with 1-3 entries leaves the occupancy unchanged and preserves order.
REQ-024 out_valid = 1 exactly when the FIFO is non-empty; out_instr and out_addr are held stable until popped.
REQ-025 The address counter starts at 0x0000_3000 and advances by 4 on each output handshake, wrapping modulo 2^32.
REQ-026 out_addr presents the counter value for the head entry.
REQ-027 An illegal op_sel that is accepted is not enqueued; err pulses high for the following cycle only.
REQ-028 err_cnt increments on each illegal accept, saturating at 0xFF.
REQ-029 flush takes priority over same-cycle push and pop:
- FIFO becomes empty and the address counter returns to 0x3000.
- The request in that cycle is dropped.
- err_cnt is retained.

Reset
REQ-030 On reset: FIFO empty, out_valid = 0, in_ready = 1, out_instr = 0, out_addr = 0x0000_3000, err = 0, err_cnt = 0.
REQ-031 Reset mid-transfer discards all queued words; no partial word is ever emitted.

Configuration
REQ-032 Macro INSTR_ENC_JALR_EN selects jalr support.
- Defined: op_sel 11 encodes jalr per REQ-016/REQ-018.
- Undefined: op_sel 11 is illegal per REQ-027.

Structure
REQ-033 Opcode and func constants and the op_sel enumeration live in the shared definitions file used by the decoder.
REQ-034 The FIFO is a sub-module named enc_fifo, parameterised on width (64: instr plus tag) and depth (4).

Verification
REQ-035 Encoding checks:
- add rs=1 rt=2 rd=3 -> out_instr 0x00221820 at out_addr 0x3000.
- ori rt=8 imm16=0x1234 -> 0x34081234.
- lw rs=29 rt=31 imm16=0xFFFC -> 0x8FBFFFFC.
- sll rt=2 rd=4 shamt=3, with nonzero rs driven -> 0x000220C0.
- jal imm26=0xC00 -> 0x0C000C00.
REQ-036 Backpressure: hold out_ready=0 and push 5 legal requests -> in_ready drops after the 4th; release -> 4 words emitted in order at addresses 0x3000, 0x3004, 0x3008, 0x300C.
REQ-037 Illegal op_sel=13 -> nothing enqueued, err high for one cycle, err_cnt 0 -> 1; 256 further illegal requests -> err_cnt stays at 0xFF.
REQ-038 Flush with 3 entries queued and a push in the same cycle -> out_valid = 0 next cycle; the next legal word appears at address 0x3000.
REQ-039 With INSTR_ENC_JALR_EN undefined, op_sel=11 -> err pulse; with it defined, rs=5 rd=31 -> 0x00A0F809.
REQ-040 Assert reset with 2 words queued and out_ready=1 -> out_valid = 0 immediately; no further words emitted.
